// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster generator: standard mode timings and
// test-pattern codes.
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam int  VGA640_H_ACTIVE = 640;
    localparam int  VGA640_H_FP     = 16;
    localparam int  VGA640_H_SYNC   = 96;
    localparam int  VGA640_H_BP     = 48;
    localparam int  VGA640_V_ACTIVE = 480;
    localparam int  VGA640_V_FP     = 10;
    localparam int  VGA640_V_SYNC   = 2;
    localparam int  VGA640_V_BP     = 33;
    localparam bit  VGA640_HS_POL   = 1'b0;
    localparam bit  VGA640_VS_POL   = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam int  SVGA800_H_ACTIVE = 800;
    localparam int  SVGA800_H_FP     = 40;
    localparam int  SVGA800_H_SYNC   = 128;
    localparam int  SVGA800_H_BP     = 88;
    localparam int  SVGA800_V_ACTIVE = 600;
    localparam int  SVGA800_V_FP     = 1;
    localparam int  SVGA800_V_SYNC   = 4;
    localparam int  SVGA800_V_BP     = 23;
    localparam bit  SVGA800_HS_POL   = 1'b1;
    localparam bit  SVGA800_VS_POL   = 1'b1;

    typedef enum logic [1:0] {
        PAT_OFF   = 2'd0,
        PAT_WHITE = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and whatever consumes the
// sync/pixel stream and supplies enable and pattern selection (slave).
interface vga_timing_gen_if #(
    parameter int CW     = 10,
    parameter int N_LEDS = 2
);
    logic              en;
    logic [1:0]        pattern_sel;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [CW-1:0]     x;
    logic [CW-1:0]     y;
    logic [2:0]        rgb;
    logic              line_start;
    logic              frame_start;
    logic [N_LEDS-1:0] leds;

    modport master (
        input  en, pattern_sel,
        output hsync, vsync, de, x, y, rgb, line_start, frame_start, leds
    );

    modport slave (
        output en, pattern_sel,
        input  hsync, vsync, de, x, y, rgb, line_start, frame_start, leds
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and
// sync-window flags decoded from the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output logic          active_o,
    output logic          sync_o
);

    localparam int          TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [31:0] LAST_U    = 32'(TOTAL - 1);
    localparam logic [31:0] ACTIVE_U  = 32'(ACTIVE);
    localparam logic [31:0] SYNC_LO_U = 32'(ACTIVE + FP);
    localparam logic [31:0] SYNC_HI_U = 32'(ACTIVE + FP + SYNC);

    if (TOTAL - 1 > (2 ** CW) - 1) begin : g_range_err
        $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   cnt_u;

    assign cnt_u    = 32'(cnt_q);
    assign cnt_o    = cnt_q;
    assign wrap_o   = (cnt_u == LAST_U);
    assign active_o = (cnt_u < ACTIVE_U);
    assign sync_o   = (cnt_u >= SYNC_LO_U) && (cnt_u < SYNC_HI_U);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered sync/DE/coordinate outputs,
// frame-latched test patterns and a frame-group heartbeat counter on LEDs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int CW           = 10,
    parameter int BAR_SHIFT    = 7,
    parameter int CHK_SHIFT    = 5,
    parameter int N_LEDS       = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.master bus
);

    localparam int            FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] hc, vc;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap_unused, v_active, v_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.en),
        .cnt_o    (hc),
        .wrap_o   (h_wrap),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.en && h_wrap),
        .cnt_o    (vc),
        .wrap_o   (v_wrap_unused),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    logic              de_q, de_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [2:0]        rgb_q, rgb_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic              ls_q, ls_d, fs_q, fs_d;
    pattern_e          pat_q, pat_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              counting_q, counting_d;

    logic              origin;
    pattern_e          pat_cur;
    logic [2:0]        rgb_pat;

    always_comb begin
        de_d       = de_q;
        x_d        = x_q;
        y_d        = y_q;
        rgb_d      = rgb_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        ls_d       = 1'b0;
        fs_d       = 1'b0;
        pat_d      = pat_q;
        fcnt_d     = fcnt_q;
        leds_d     = leds_q;
        counting_d = counting_q;

        origin  = (hc == '0) && (vc == '0);
        // The pixel at (0,0) already uses the newly latched pattern
        pat_cur = origin ? pattern_e'(bus.pattern_sel) : pat_q;

        case (pat_cur)
            PAT_WHITE: rgb_pat = 3'b111;
            PAT_BARS:  rgb_pat = hc[BAR_SHIFT+2 -: 3];
            PAT_CHECK: rgb_pat = {3{hc[CHK_SHIFT] ^ vc[CHK_SHIFT]}};
            default:   rgb_pat = 3'b000;
        endcase

        if (bus.en) begin
            de_d  = h_active && v_active;
            x_d   = de_d ? hc : '0;
            y_d   = de_d ? vc : '0;
            rgb_d = de_d ? rgb_pat : 3'b000;
            hs_d  = h_sync ? HS_POL : ~HS_POL;
            vs_d  = v_sync ? VS_POL : ~VS_POL;
            ls_d  = (hc == '0);
            fs_d  = origin;

            if (origin) begin
                pat_d = pat_cur;
                // The frame that starts right after reset has not completed one
                if (!counting_q) begin
                    counting_d = 1'b1;
                end else if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = '0;
                    leds_d = leds_q + N_LEDS'(1);
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            rgb_q      <= 3'b000;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            ls_q       <= 1'b0;
            fs_q       <= 1'b0;
            pat_q      <= PAT_OFF;
            fcnt_q     <= '0;
            leds_q     <= '0;
            counting_q <= 1'b0;
        end else begin
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            ls_q       <= ls_d;
            fs_q       <= fs_d;
            pat_q      <= pat_d;
            fcnt_q     <= fcnt_d;
            leds_q     <= leds_d;
            counting_q <= counting_d;
        end
    end

    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.rgb         = rgb_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.leds        = leds_q;

endmodule
